// File: rtl/aluaddsub_seq.sv
// ---------------------------------------------------------------------------
// aluaddsub_seq
//   Multi-cycle two's-complement add/subtract unit. Operands are latched on
//   accept and summed CHUNK bits per cycle, LSB chunk first, through a
//   registered carry. This keeps the carry chain CHUNK bits long no matter
//   how wide WIDTH is. The unit reports signed overflow (pos/neg), carry-out
//   and zero flags alongside the result.
//
//   Optional feature macro: ALU_ADDSUB_SAT_EN
//     If defined, an overflowing result saturates to max-positive or
//     min-negative. The overflow and carry flags still describe the
//     unsaturated operation, and zero is computed on the saturated result.
//     If not defined, the result wraps modulo 2^WIDTH.
//
//   Handshake: a transfer happens on a rising clk edge when valid and ready
//   are both high in that cycle. in_ready is high only in IDLE (and not in
//   reset). out_valid stays high, and result/flags stay stable, until a
//   cycle with out_ready high.
//
// Parameters
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits added per RUN cycle (1..WIDTH)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  operand handshake; a, b, sub are sampled on accept
//   sub             0: a+b, 1: a-b (computed as a + ~b + 1)
//   out_valid/ready result handshake
//   result          sum or difference (registered)
//   pos_overflow    positive signed overflow
//   neg_overflow    negative signed overflow
//   carry_out       carry out of the MSB; for sub, 1 means no borrow
//   zero            final result == 0
// ---------------------------------------------------------------------------
module aluaddsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             pos_overflow,
    output logic             neg_overflow,
    output logic             carry_out,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_chunk
        $error("aluaddsub_seq: CHUNK must be in 1..WIDTH");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("aluaddsub_seq: WIDTH must be a multiple of CHUNK");
    end

`ifdef ALU_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;          // effective B: ~b for subtract
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             pov_q, pov_d;
    logic             nov_q, nov_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] full;              // result with the current chunk inserted
    logic             pov_w, nov_w;

    always_comb begin
        // Pick the operand chunks selected by count, using constant part-selects.
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (count_q == CNT_W'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end
        sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);

        full = result_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (count_q == CNT_W'(k)) begin
                full[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end
        pov_w = ~a_q[WIDTH-1] & ~b_q[WIDTH-1] &  full[WIDTH-1];
        nov_w =  a_q[WIDTH-1] &  b_q[WIDTH-1] & ~full[WIDTH-1];

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        count_d     = count_q;
        result_d    = result_q;
        pov_d       = pov_q;
        nov_d       = nov_q;
        cout_d      = cout_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;       // the +1 of the two's-complement negate
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                result_d = full;
                carry_d  = sum[CHUNK];
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST) begin
                    pov_d  = pov_w;
                    nov_d  = nov_w;
                    cout_d = sum[CHUNK];
`ifdef ALU_ADDSUB_SAT_EN
                    if (pov_w) begin
                        result_d = MAX_POS;
                    end else if (nov_w) begin
                        result_d = MIN_NEG;
                    end
`endif
                    zero_d      = (result_d == '0);
                    out_valid_d = 1'b1;
                    count_d     = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            result_q    <= '0;
            pov_q       <= 1'b0;
            nov_q       <= 1'b0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            count_q     <= count_d;
            result_q    <= result_d;
            pov_q       <= pov_d;
            nov_q       <= nov_d;
            cout_q      <= cout_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE) & ~rst;
    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign pos_overflow = pov_q;
    assign neg_overflow = nov_q;
    assign carry_out    = cout_q;
    assign zero         = zero_q;

endmodule
